acq: RTL and testbench

Stream acquisition block: the receive-side counterpart of the arbitrary signal generator. It accepts an AXI4-stream of samples (typically from the ADC path) and writes them into a circular buffer. An FSM handles pre-trigger fill, trigger detection and post-trigger counting. The CPU reads the captured buffer and status over the system bus. One instance per channel, instantiated beside the generator in the scope/generator subsystem.

---
 rtl/acq_pkg.sv | 5 +
 rtl/axi4_stream_if.sv | 15 +
 rtl/sys_bus_if.sv | 16 +
 rtl/acq_mem.sv | 23 ++
 rtl/acq.sv | 131 +++++++++++++
 tb/tb_acq.sv | 231 +++++++++++++++++++++++
 6 files changed

// File: rtl/acq_pkg.sv
// acq_pkg: shared FSM state encoding and bus packing constants for the acquisition block.
package acq_pkg;
  typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, STOP} acq_state_t;
  localparam int BUS_PK = 2;
endpackage

// File: rtl/axi4_stream_if.sv
// axi4_stream_if: AXI4-stream sample bundle; modport d is the sink side.
interface axi4_stream_if #(
  parameter type DT = logic [15:0]
) (
  input logic ACLK,
  input logic ARESETn
);
  DT TDATA;
  logic [($bits(DT)+7)/8-1:0] TKEEP;
  logic TLAST;
  logic TVALID;
  logic TREADY;
  modport s (input ACLK, ARESETn, TREADY, output TDATA, TKEEP, TLAST, TVALID);
  modport d (input ACLK, ARESETn, TDATA, TKEEP, TLAST, TVALID, output TREADY);
endinterface

// File: rtl/sys_bus_if.sv
// sys_bus_if: simple CPU system bus; modport s is the slave side.
interface sys_bus_if (
  input logic clk,
  input logic rstn
);
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  sel;
  logic        wen;
  logic        ren;
  logic [31:0] rdata;
  logic        err;
  logic        ack;
  modport m (input clk, rstn, rdata, err, ack, output addr, wdata, sel, wen, ren);
  modport s (input clk, rstn, addr, wdata, sel, wen, ren, output rdata, err, ack);
endinterface

// File: rtl/acq_mem.sv
// acq_mem: capture RAM, one sample-wide write port and a registered BUS_PK-sample read port.
module acq_mem
  import acq_pkg::*;
#(
  parameter type DT  = logic [15:0],
  parameter int  CWM = 14
) (
  input  logic                             clk,
  input  logic                             we,
  input  logic [CWM-1:0]                   waddr,
  input  DT                                wdata,
  input  logic                             re,
  input  logic [CWM-$clog2(BUS_PK)-1:0]    raddr,
  output logic [BUS_PK*$bits(DT)-1:0]      rdata
);
  DT mem [2**CWM];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re)
      for (int i = 0; i < BUS_PK; i++)
        rdata[i*$bits(DT) +: $bits(DT)] <= mem[CWM'(int'(raddr) * BUS_PK + i)];
  end
endmodule

// File: rtl/acq.sv
// acq: stream capture into a circular buffer with pre/post-trigger FSM and bus readback.
// Define ACQ_PRE_TRG_EN to implement the PRE state; otherwise arming goes straight to ARMED.
module acq
  import acq_pkg::*;
#(
  parameter int  TN  = 1,
  parameter type DT  = logic [15:0],
  parameter int  CWM = 14,
  parameter int  CWP = 32
) (
  axi4_stream_if.d         sti,
  input  logic             ctl_rst,
  input  logic             ctl_acq,
  input  logic             ctl_stp,
  input  logic [TN-1:0]    trg_i,
  output logic             trg_o,
  output logic             irq_trg,
  output logic             irq_stp,
  input  logic [TN-1:0]    cfg_trg,
  input  logic [CWP-1:0]   cfg_pre,
  input  logic [CWP-1:0]   cfg_pst,
  output logic [CWM-1:0]   sts_ptr,
  output logic [CWM-1:0]   sts_tpt,
  output logic [CWP-1:0]   sts_pre,
  output logic [CWP-1:0]   sts_pst,
  output logic             sts_acq,
  output logic             sts_trg,
  sys_bus_if.s             bus
);
  localparam int WA = CWM - $clog2(BUS_PK);
  logic clk, rst_n;
  acq_state_t state;
  logic wr, trg;
  logic [CWP-1:0] pre_inc, pst_inc;
  logic unused;
  assign clk        = sti.ACLK;
  assign rst_n      = sti.ARESETn;
  assign sti.TREADY = 1'b1;
  assign sts_acq    = (state == PRE) || (state == ARMED) || (state == POST);
  // a transfer during a control override is dropped so the RAM and pointer stay in step
  assign wr         = sti.TVALID & sts_acq & ~ctl_rst & ~ctl_stp;
  assign trg        = |(trg_i & cfg_trg);
  assign pre_inc    = (sts_pre == '1) ? sts_pre : sts_pre + 1'b1;
  assign pst_inc    = sts_pst + 1'b1;
  assign bus.err    = 1'b0;
  assign unused     = ^{sti.TKEEP, bus.clk, bus.rstn, bus.wdata, bus.sel,
                        bus.addr[31:WA+2], bus.addr[1:0], cfg_pre};
  acq_mem #(.DT(DT), .CWM(CWM)) mem_i (
    .clk   (clk),
    .we    (wr),
    .waddr (sts_ptr),
    .wdata (sti.TDATA),
    .re    (bus.ren),
    .raddr (bus.addr[WA+1:2]),
    .rdata (bus.rdata)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.ack <= 1'b0;
    else        bus.ack <= bus.wen | bus.ren;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sts_ptr <= '0;
      sts_tpt <= '0;
      sts_pre <= '0;
      sts_pst <= '0;
      sts_trg <= 1'b0;
      trg_o   <= 1'b0;
      irq_trg <= 1'b0;
      irq_stp <= 1'b0;
    end else begin
      trg_o   <= 1'b0;
      irq_trg <= 1'b0;
      irq_stp <= 1'b0;
      if (ctl_rst) begin
        state   <= IDLE;
        sts_ptr <= '0;
        sts_tpt <= '0;
        sts_pre <= '0;
        sts_pst <= '0;
        sts_trg <= 1'b0;
      end else if (ctl_stp) begin
        state <= STOP;
      end else if (ctl_acq && !sts_acq) begin
        sts_pre <= '0;
        sts_pst <= '0;
        sts_trg <= 1'b0;
`ifdef ACQ_PRE_TRG_EN
        state   <= (cfg_pre == '0) ? ARMED : PRE;
`else
        state   <= ARMED;
`endif
      end else begin
        if (wr) sts_ptr <= sts_ptr + 1'b1;
        case (state)
`ifdef ACQ_PRE_TRG_EN
          PRE: if (wr) begin
            sts_pre <= pre_inc;
            if (pre_inc == cfg_pre) state <= ARMED;
          end
`endif
          ARMED: begin
            if (wr) sts_pre <= pre_inc;
            if (trg) begin
              sts_tpt <= sts_ptr;
              sts_trg <= 1'b1;
              trg_o   <= 1'b1;
              irq_trg <= 1'b1;
              irq_stp <= (cfg_pst == '0);
              state   <= (cfg_pst == '0) ? STOP : POST;
            end
          end
          POST: if (wr) begin
            sts_pst <= pst_inc;
            if (pst_inc == cfg_pst) begin
              state   <= STOP;
              irq_stp <= 1'b1;
            end
          end
          default: ;
        endcase
        // premature end of stream overrides whatever the FSM chose this cycle
        if (wr && sti.TLAST) begin
          state   <= STOP;
          irq_stp <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_acq.sv
// tb_acq: directed scoreboard bench for acq (CWM=4, TN=2); handles both ACQ_PRE_TRG_EN builds.
module tb_acq;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  axi4_stream_if #(.DT(logic [15:0])) sti (.ACLK(clk), .ARESETn(rstn));
  sys_bus_if bus (.clk(clk), .rstn(rstn));

  logic        ctl_rst = 0, ctl_acq = 0, ctl_stp = 0;
  logic [1:0]  trg_i = 0, cfg_trg = 2'b01;
  logic [31:0] cfg_pre = 0, cfg_pst = 0;
  logic        trg_o, irq_trg, irq_stp, sts_acq, sts_trg;
  logic [3:0]  sts_ptr, sts_tpt;
  logic [31:0] sts_pre, sts_pst;

  acq #(.TN(2), .DT(logic [15:0]), .CWM(4), .CWP(32)) dut (
    .sti(sti), .ctl_rst(ctl_rst), .ctl_acq(ctl_acq), .ctl_stp(ctl_stp),
    .trg_i(trg_i), .trg_o(trg_o), .irq_trg(irq_trg), .irq_stp(irq_stp),
    .cfg_trg(cfg_trg), .cfg_pre(cfg_pre), .cfg_pst(cfg_pst),
    .sts_ptr(sts_ptr), .sts_tpt(sts_tpt), .sts_pre(sts_pre), .sts_pst(sts_pst),
    .sts_acq(sts_acq), .sts_trg(sts_trg), .bus(bus)
  );

  typedef struct {logic tr; logic st; logic [3:0] tpt; int pst; int pre; int cyc;} ev_t;
  typedef struct {bit rd; logic [31:0] d; int cyc;} rd_t;
  ev_t exp_ev[$];
  rd_t exp_rd[$];
  int n_cmp = 0, n_bad = 0;
  int eptr = 0;
  int a = 0;
  logic [15:0] shadow [16];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input logic tr, input logic st, input int tpt, input int pst, input int pre, input int c);
    ev_t e;
    e.tr = tr; e.st = st; e.tpt = 4'(tpt % 16); e.pst = pst; e.pre = pre; e.cyc = c;
    exp_ev.push_back(e);
  endtask

  task automatic fill(input int p0, input int base, input int j0, input int j1);
    for (int j = j0; j <= j1; j++) shadow[(p0 + j - 1) % 16] = 16'(base + j);
  endtask

  task automatic rd(input int k, input logic [31:0] exp);
    rd_t r;
    r.rd = 1'b1; r.d = exp; r.cyc = cyc + 1;
    exp_rd.push_back(r);
    bus.addr = 32'(k * 4);
    bus.ren = 1'b1;
    @(negedge clk);
    bus.ren = 1'b0;
    @(negedge clk);
  endtask

  task automatic read_all();
    for (int k = 0; k < 8; k++) rd(k, {shadow[2*k+1], shadow[2*k]});
  endtask

  task automatic run(input int n, input int base, input int trg_a = -1, input int trg_b = -1,
                     input int msk_j = -1, input int rst_j = -1, input int stp_j = -1, input int last_j = -1);
    for (int j = 0; j < n; j++) begin
      ctl_acq     = (j == 0) || (j == rst_j);
      ctl_rst     = (j == rst_j);
      ctl_stp     = (j == stp_j);
      trg_i       = (j == trg_a || j == trg_b) ? 2'b01 : (j == msk_j) ? 2'b10 : 2'b00;
      sti.TLAST   = (j == last_j);
      sti.TVALID  = 1'b1;
      sti.TDATA   = 16'(base + j);
      @(negedge clk);
    end
    {ctl_acq, ctl_rst, ctl_stp, sti.TLAST, sti.TVALID} = '0;
    trg_i = '0;
  endtask

  // monitor: pops the scoreboard whenever the DUT raises an event or a bus ack
  initial begin
    ev_t e;
    rd_t r;
    forever begin
      @(posedge clk);
      #1;
      if (rstn && (trg_o | irq_trg | irq_stp)) begin
        if (exp_ev.size() == 0) chk("unexpected_event", {trg_o, irq_trg, irq_stp}, 0);
        else begin
          e = exp_ev.pop_front();
          chk("event_flags", {trg_o, irq_trg, irq_stp}, {e.tr, e.tr, e.st});
          chk("event_cycle", cyc, e.cyc);
          if (e.tr) chk("sts_tpt", sts_tpt, e.tpt);
          if (e.st) begin
            chk("sts_pst", sts_pst, e.pst);
            chk("sts_pre", sts_pre, e.pre);
            chk("sts_acq_at_stop", sts_acq, 0);
          end
        end
      end
      if (rstn && bus.ack) begin
        if (exp_rd.size() == 0) chk("unexpected_ack", bus.ack, 0);
        else begin
          r = exp_rd.pop_front();
          chk("ack_cycle", cyc, r.cyc);
          chk("bus_err", bus.err, 0);
          if (r.rd) chk("bus_rdata", bus.rdata, r.d);
        end
      end
    end
  end

  initial begin
    rd_t w;
    bus.addr = 0; bus.wdata = 0; bus.sel = 4'hf; bus.wen = 0; bus.ren = 0;
    sti.TDATA = 0; sti.TKEEP = 2'b11; sti.TLAST = 0; sti.TVALID = 0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("reset_ptr_tpt", {sts_ptr, sts_tpt}, 0);
    chk("reset_pre_pst", {sts_pre, sts_pst}, 0);
    chk("reset_flags", {sts_acq, sts_trg, trg_o, irq_trg, irq_stp, bus.ack}, 0);
    chk("tready", sti.TREADY, 1);

    // T1: pre 4, post 8, trigger 10 cycles after arm
    cfg_pre = 4; cfg_pst = 8;
    a = cyc;
    push_ev(1, 0, eptr + 9, 0, 0, a + 11);
    push_ev(0, 1, 0, 8, 10, a + 19);
    run(.n(23), .base('h1000), .trg_a(10));
    fill(eptr, 'h1000, 1, 18);
    eptr = (eptr + 18) % 16;
    chk("t1_ptr", sts_ptr, eptr);
    chk("t1_sts_trg", sts_trg, 1);
    read_all();

    // T2: pre 100, trigger at 50 (PRE when enabled), masked pulse at 30, trigger at 103
    cfg_pre = 100; cfg_pst = 2;
    a = cyc;
`ifdef ACQ_PRE_TRG_EN
    push_ev(1, 0, eptr + 102, 0, 0, a + 104);
    push_ev(0, 1, 0, 2, 103, a + 106);
    run(.n(110), .base('h2000), .trg_a(50), .trg_b(103), .msk_j(30));
    fill(eptr, 'h2000, 1, 105);
    eptr = (eptr + 105) % 16;
`else
    push_ev(1, 0, eptr + 49, 0, 0, a + 51);
    push_ev(0, 1, 0, 2, 50, a + 53);
    run(.n(110), .base('h2000), .trg_a(50), .trg_b(103), .msk_j(30));
    fill(eptr, 'h2000, 1, 52);
    eptr = (eptr + 52) % 16;
`endif
    chk("t2_ptr", sts_ptr, eptr);
    read_all();

    // T3: zero post count, trigger and stop interrupts coincide
    cfg_pre = 0; cfg_pst = 0;
    a = cyc;
    push_ev(1, 1, eptr + 2, 0, 3, a + 4);
    run(.n(8), .base('h3000), .trg_a(3));
    fill(eptr, 'h3000, 1, 3);
    eptr = (eptr + 3) % 16;
    chk("t3_ptr", sts_ptr, eptr);

    // T4: 41 samples through a 16-entry buffer
    cfg_pst = 40;
    a = cyc;
    push_ev(1, 0, eptr, 0, 0, a + 2);
    push_ev(0, 1, 0, 40, 1, a + 42);
    run(.n(46), .base('h4000), .trg_a(1));
    fill(eptr, 'h4000, 1, 41);
    eptr = (eptr + 41) % 16;
    chk("t4_ptr", sts_ptr, eptr);
    read_all();

    // T5: ctl_rst together with ctl_acq mid-POST, then a clean restart
    cfg_pst = 20;
    a = cyc;
    push_ev(1, 0, eptr + 1, 0, 0, a + 3);
    run(.n(10), .base('h5000), .trg_a(2), .rst_j(8));
    chk("t5_rst_ptr_tpt", {sts_ptr, sts_tpt}, 0);
    chk("t5_rst_pre_pst", {sts_pre, sts_pst}, 0);
    chk("t5_rst_flags", {sts_acq, sts_trg}, 0);
    eptr = 0;
    cfg_pst = 3;
    a = cyc;
    push_ev(1, 0, 1, 0, 0, a + 3);
    push_ev(0, 1, 0, 3, 2, a + 6);
    run(.n(8), .base('h5100), .trg_a(2));
    fill(0, 'h5100, 1, 5);
    eptr = 5;
    rd(0, 32'h5102_5101);
    rd(1, 32'h5104_5103);

    // T6: TLAST on the third post sample
    cfg_pst = 10;
    a = cyc;
    push_ev(1, 0, 5, 0, 0, a + 2);
    push_ev(0, 1, 0, 3, 1, a + 5);
    run(.n(8), .base('h6000), .trg_a(1), .last_j(4));
    eptr = 9;
    chk("t6_ptr", sts_ptr, eptr);
    rd(0, 32'h5102_5101);
    rd(2, 32'h6001_5105);

    // T7: abort, then a discarded bus write
    a = cyc;
    run(.n(6), .base('h7000), .stp_j(3));
    chk("t7_acq", sts_acq, 0);
    chk("t7_ptr", sts_ptr, 11);
    chk("t7_sts_trg", sts_trg, 0);
    w.rd = 1'b0; w.d = '0; w.cyc = cyc + 1;
    exp_rd.push_back(w);
    bus.addr = 0; bus.wdata = 32'hdead_beef; bus.wen = 1'b1;
    @(negedge clk);
    bus.wen = 1'b0;
    @(negedge clk);
    rd(0, 32'h5102_5101);

    for (int i = 0; i < 50 && (exp_ev.size() != 0 || exp_rd.size() != 0); i++) @(negedge clk);
    chk("events_left", exp_ev.size(), 0);
    chk("reads_left", exp_rd.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
